// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants: control-bundle layout, forward codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int CTRL_W = 12;

  // Bit offsets into {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,Jalr,ALUSrc,ALUControl[3:0]}
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_RESSRC   = 9;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_JUMP     = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_JALR     = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUCTL   = 0;

  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] FWD_W = 2'b01;

  function automatic logic ctrl_alusrc(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_ALUSRC];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module      : fwd_mux
// Description : EX operand select: x0 mask, stall-hold override, M/W/RF source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_i,
  input  logic            hold_vld_i,
  input  logic [XLEN-1:0] hold_i,
  input  logic [1:0]      fd_i,
  input  logic [XLEN-1:0] alu_m_i,
  input  logic [XLEN-1:0] res_w_i,
  input  logic [XLEN-1:0] rf_i,
  output logic [XLEN-1:0] src_o
);

  // M is checked before W so that fd=2'b11 picks the newest producer.
  always_comb begin
    src_o = rf_i;
    if (rs_i == 5'd0) begin
      src_o = '0;
    end else if (hold_vld_i) begin
      src_o = hold_i;
    end else if ((fd_i & FWD_M) == FWD_M) begin
      src_o = alu_m_i;
    end else if ((fd_i & FWD_W) == FWD_W) begin
      src_o = res_w_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with stall/flush, forwarding and
//               stall-time operand hold. IDEX_PERF_CNT_EN adds bubble/stall
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic [4:0]        rdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [1:0]        fd1,
  input  logic [1:0]        fd2,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ResultW,
  output logic              validE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [4:0]        rs1E,
  output logic [4:0]        rs2E,
  output logic [4:0]        rdE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   WriteDataE,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic [XLEN-1:0]   SrcBE
);

  logic              validE_q,   validE_d;
  logic [CTRL_W-1:0] ctrlE_q,    ctrlE_d;
  logic [4:0]        rs1E_q,     rs1E_d;
  logic [4:0]        rs2E_q,     rs2E_d;
  logic [4:0]        rdE_q,      rdE_d;
  logic [XLEN-1:0]   RD1E_q,     RD1E_d;
  logic [XLEN-1:0]   RD2E_q,     RD2E_d;
  logic [XLEN-1:0]   ImmExtE_q,  ImmExtE_d;
  logic [XLEN-1:0]   PCE_q,      PCE_d;
  logic [XLEN-1:0]   PCPlus4E_q, PCPlus4E_d;
  logic              hold_vld_q, hold_vld_d;
  logic [XLEN-1:0]   hold1_q,    hold1_d;
  logic [XLEN-1:0]   hold2_q,    hold2_d;

  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .rs_i      (rs1E_q),
    .hold_vld_i(hold_vld_q),
    .hold_i    (hold1_q),
    .fd_i      (fd1),
    .alu_m_i   (ALUResultM),
    .res_w_i   (ResultW),
    .rf_i      (RD1E_q),
    .src_o     (SrcAE)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .rs_i      (rs2E_q),
    .hold_vld_i(hold_vld_q),
    .hold_i    (hold2_q),
    .fd_i      (fd2),
    .alu_m_i   (ALUResultM),
    .res_w_i   (ResultW),
    .rf_i      (RD2E_q),
    .src_o     (WriteDataE)
  );

  always_comb begin
    validE_d   = validE_q;
    ctrlE_d    = ctrlE_q;
    rs1E_d     = rs1E_q;
    rs2E_d     = rs2E_q;
    rdE_d      = rdE_q;
    RD1E_d     = RD1E_q;
    RD2E_d     = RD2E_q;
    ImmExtE_d  = ImmExtE_q;
    PCE_d      = PCE_q;
    PCPlus4E_d = PCPlus4E_q;
    hold_vld_d = hold_vld_q;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    if (FlushE) begin
      validE_d   = 1'b0;
      ctrlE_d    = '0;
      rs1E_d     = '0;
      rs2E_d     = '0;
      rdE_d      = '0;
      RD1E_d     = '0;
      RD2E_d     = '0;
      ImmExtE_d  = '0;
      PCE_d      = '0;
      PCPlus4E_d = '0;
      hold_vld_d = 1'b0;
      hold1_d    = '0;
      hold2_d    = '0;
    end else if (StallE) begin
      // Snapshot the forwarded operands on the first stalled edge; the
      // producer may retire from M/W before the stall releases.
      if (!hold_vld_q) begin
        hold_vld_d = 1'b1;
        hold1_d    = SrcAE;
        hold2_d    = WriteDataE;
      end
    end else begin
      validE_d   = validD;
      ctrlE_d    = validD ? ctrlD : '0;
      rs1E_d     = rs1D;
      rs2E_d     = rs2D;
      rdE_d      = rdD;
      RD1E_d     = RD1D;
      RD2E_d     = RD2D;
      ImmExtE_d  = ImmExtD;
      PCE_d      = PCD;
      PCPlus4E_d = PCPlus4D;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validE_q   <= 1'b0;
      ctrlE_q    <= '0;
      rs1E_q     <= '0;
      rs2E_q     <= '0;
      rdE_q      <= '0;
      RD1E_q     <= '0;
      RD2E_q     <= '0;
      ImmExtE_q  <= '0;
      PCE_q      <= '0;
      PCPlus4E_q <= '0;
      hold_vld_q <= 1'b0;
      hold1_q    <= '0;
      hold2_q    <= '0;
    end else begin
      validE_q   <= validE_d;
      ctrlE_q    <= ctrlE_d;
      rs1E_q     <= rs1E_d;
      rs2E_q     <= rs2E_d;
      rdE_q      <= rdE_d;
      RD1E_q     <= RD1E_d;
      RD2E_q     <= RD2E_d;
      ImmExtE_q  <= ImmExtE_d;
      PCE_q      <= PCE_d;
      PCPlus4E_q <= PCPlus4E_d;
      hold_vld_q <= hold_vld_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
    end
  end

  assign validE   = validE_q;
  assign ctrlE    = ctrlE_q;
  assign rs1E     = rs1E_q;
  assign rs2E     = rs2E_q;
  assign rdE      = rdE_q;
  assign PCE      = PCE_q;
  assign PCPlus4E = PCPlus4E_q;
  assign ImmExtE  = ImmExtE_q;
  assign SrcBE    = ctrl_alusrc(ctrlE_q) ? ImmExtE_q : WriteDataE;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (StallE && !FlushE && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

`default_nettype wire
